chunked_serial_adder: RTL and testbench

Parametrised multi-cycle adder. It computes a WIDTH-bit sum of two operands plus carry-in, processing CHUNK bits per clock through a single CHUNK-bit adder slice with a registered carry. It is the area-reduced successor to the single-bit full-adder cell: a start/busy/done handshake replaces combinational evaluation. It sits behind the datapath control FSM, which issues one addition at a time.

---
 rtl/chunked_serial_adder.sv | 94 +++++++++
 tb/tb_chunked_serial_adder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: adds CHUNK bits per clock through one slice with a registered carry.
// start/busy/done handshake; sum/cout hold the last completed result.
module chunked_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned K  = WIDTH / CHUNK;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  ar, br, res, res_nxt, s_ext;
  logic              carry;
  logic [CW-1:0]     cnt;
  logic [CHUNK:0]    slice;
  logic              accept, last;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == LAST);

  // Slice result enters at the MSB end; the shift-or form also covers CHUNK == WIDTH.
  always_comb begin
    slice = {1'b0, ar[CHUNK-1:0]} + {1'b0, br[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    s_ext = '0;
    s_ext[CHUNK-1:0] = slice[CHUNK-1:0];
    res_nxt = (res >> CHUNK) | (s_ext << (WIDTH - CHUNK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar    <= '0;
      br    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      ar    <= a;
      br    <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      ar    <= ar >> CHUNK;
      br    <= br >> CHUNK;
      carry <= slice[CHUNK];
      res   <= res_nxt;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= res_nxt;
        cout <= slice[CHUNK];
      end
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed-vector bench for chunked_serial_adder: 16/4 main instance plus
// exhaustive 4-bit sweeps for CHUNK = 1, 2, 4.
module tb_chunked_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout;
  logic [15:0] sum;

  logic       st [3];
  logic [3:0] ax [3];
  logic [3:0] bx [3];
  logic       cx [3];
  logic       bz [3];
  logic       dn [3];
  logic [3:0] sm [3];
  logic       co [3];

  int total = 0;
  int bad = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  for (genvar g = 0; g < 3; g++) begin : sw
    chunked_serial_adder #(.WIDTH(4), .CHUNK(1 << g)) u (
      .clk(clk), .rst_n(rst_n), .start(st[g]), .a(ax[g]), .b(bx[g]), .cin(cx[g]),
      .busy(bz[g]), .done(dn[g]), .sum(sm[g]), .cout(co[g])
    );
  end

  always @(negedge clk) begin
    if (busy && done) overlap++;
    for (int g = 0; g < 3; g++) if (bz[g] && dn[g]) overlap++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or after the bound).
  task automatic do_add(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        output int lat, output int bcnt);
    start = 1'b1; a = av; b = bv; cin = ci;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    bcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = i - 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, bcnt, dcount, first_t, second_t;
    logic [16:0] r1, r2;
    int lx [3];
    logic [4:0] rs [3];
    logic [8:0] vv;
    logic [4:0] exp5;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0};
    vecs[4] = '{16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
    for (int g = 0; g < 3; g++) begin
      st[g] = 1'b0; ax[g] = '0; bx[g] = '0; cx[g] = 1'b0;
    end

    #2;
    chk("reset_outputs", {14'd0, busy, done, cout, sum}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcnt);
      chk($sformatf("vec%0d_result", i), {15'd0, cout, sum}, {15'd0, vecs[i].cout, vecs[i].sum});
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, 4);
      @(negedge clk);
      chk($sformatf("vec%0d_done_one_cycle", i), {30'd0, done, busy}, 32'd0);
    end

    // start held high: second operands presented during RUN, accepted only from DONE
    start = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
    dcount = 0; first_t = -1; second_t = -1; r1 = '0; r2 = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = 16'h8000; b = 16'h8000;
      if (done) begin
        dcount++;
        if (dcount == 1) begin first_t = i; r1 = {cout, sum}; end
        if (dcount == 2) begin second_t = i; r2 = {cout, sum}; start = 1'b0; end
      end
    end
    start = 1'b0;
    chk("b2b_first_result", {15'd0, r1}, {15'd0, 1'b0, 16'h0002});
    chk("b2b_second_result", {15'd0, r2}, {15'd0, 1'b1, 16'h0000});
    chk("b2b_first_latency", first_t, 4);
    chk("b2b_done_spacing", second_t - first_t, 5);
    chk("b2b_done_count", dcount, 2);

    // start pulsed mid-RUN with other operands is ignored
    start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int i = 3; i <= 20; i++) begin
      if (done) begin lat = i - 1; break; end
      @(negedge clk);
    end
    chk("midrun_start_result", {15'd0, cout, sum}, {15'd0, 1'b0, 16'h5555});
    chk("midrun_start_latency", lat, 4);
    @(negedge clk);
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    chk("midrun_start_no_extra_done", dcount, 0);

    // operands wander during RUN
    start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin lat = i - 1; break; end
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      @(negedge clk);
    end
    chk("operand_change_result", {15'd0, cout, sum}, {15'd0, 1'b0, 16'h3334});
    chk("operand_change_latency", lat, 4);
    @(negedge clk);

    // prior result is non-zero here, so the reset clear is observable
    do_add(16'hABCD, 16'h1234, 1'b0, lat, bcnt);
    @(negedge clk);
    start = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_midrun_outputs", {14'd0, busy, done, cout, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    chk("reset_midrun_no_done", dcount, 0);
    chk("reset_midrun_sum_held", {15'd0, cout, sum}, 32'd0);
    do_add(16'h0003, 16'h0004, 1'b0, lat, bcnt);
    chk("after_reset_result", {15'd0, cout, sum}, {15'd0, 1'b0, 16'h0007});
    chk("after_reset_latency", lat, 4);
    @(negedge clk);

    // exhaustive 4-bit sweep, CHUNK = 1, 2, 4 in parallel
    for (int v = 0; v < 512; v++) begin
      vv = 9'(v);
      for (int g = 0; g < 3; g++) begin
        st[g] = 1'b1; ax[g] = vv[3:0]; bx[g] = vv[7:4]; cx[g] = vv[8];
        lx[g] = -1; rs[g] = '0;
      end
      @(negedge clk);
      for (int g = 0; g < 3; g++) st[g] = 1'b0;
      for (int i = 1; i <= 7; i++) begin
        for (int g = 0; g < 3; g++)
          if (dn[g] && lx[g] < 0) begin lx[g] = i - 1; rs[g] = {co[g], sm[g]}; end
        @(negedge clk);
      end
      exp5 = {1'b0, vv[3:0]} + {1'b0, vv[7:4]} + {4'd0, vv[8]};
      for (int g = 0; g < 3; g++) begin
        if (rs[g] !== exp5 || lx[g] != (4 >> g)) begin
          chk($sformatf("sweep_c%0d_a%0h_b%0h_ci%0d_sum", 1 << g, vv[3:0], vv[7:4], vv[8]),
              {27'd0, rs[g]}, {27'd0, exp5});
          chk($sformatf("sweep_c%0d_a%0h_b%0h_ci%0d_lat", 1 << g, vv[3:0], vv[7:4], vv[8]),
              lx[g], 4 >> g);
        end else begin
          total += 2;
        end
      end
    end

    chk("busy_done_exclusive", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
